// File: rtl/modexp_ctrl.sv
// modexp_ctrl: Montgomery modular-exponentiation sequencer (65-bit modulus).
// A single 65x65 multiplier feeds one combinational REDC stage; the FSM
// schedules domain entry, left-to-right square-and-multiply, and domain exit.
// Optional feature macro: MODEXP_SKIP_LZ_EN -- skip the leading zero bits of
// the exponent so latency depends on its significant length.
module modexp_ctrl #(
  parameter int EXP_W = 64
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [64:0]      i_base,
  input  logic [EXP_W-1:0] i_exp,
  output logic             o_busy,
  output logic             o_done,
  output logic [64:0]      o_result
);

  localparam int CNT_W = $clog2(EXP_W);

  localparam logic [64:0] MOD_N    = 65'd21536215303153667899;
  localparam logic [64:0] N_PRIME  = 65'd1411149436910194189;
  localparam logic [64:0] R_MOD_N  = 65'd15357272844265435333;
  localparam logic [64:0] R2_MOD_N = 65'd15661607970342841481;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TO_MONT   = 3'd1,
    S_SQR       = 3'd2,
    S_MUL       = 3'd3,
    S_FROM_MONT = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  // Montgomery reduction of a*b with R = 2^65; inputs below MOD_N give u < 2n,
  // so one conditional subtraction fully reduces the result.
  function automatic logic [64:0] redc(input logic [64:0] a, input logic [64:0] b);
    logic [129:0] t;
    logic [64:0]  m;
    logic [129:0] mn;
    logic [65:0]  u;
    t  = {65'd0, a} * {65'd0, b};
    m  = t[64:0] * N_PRIME;
    mn = {65'd0, m} * {65'd0, MOD_N};
    u  = 66'(({1'b0, t} + {1'b0, mn}) >> 65);
    if (u >= {1'b0, MOD_N}) begin
      redc = 65'(u - {1'b0, MOD_N});
    end else begin
      redc = u[64:0];
    end
  endfunction

`ifdef MODEXP_SKIP_LZ_EN
  // Index of the highest set bit; zero when the vector is zero.
  function automatic logic [CNT_W-1:0] msb_index(input logic [EXP_W-1:0] v);
    logic [CNT_W-1:0] idx;
    idx = {CNT_W{1'b0}};
    for (int i = 0; i < EXP_W; i++) begin
      if (v[i]) begin
        idx = CNT_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction
`endif

  state_t             r_state;
  state_t             w_next;
  logic [64:0]        r_base;
  logic [64:0]        r_acc;
  logic [64:0]        r_bm;
  logic [EXP_W-1:0]   r_e_sh;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [64:0]        r_result;
  logic [64:0]        w_op_a;
  logic [64:0]        w_op_b;
  logic [64:0]        w_redc;
  logic               w_cur_bit;
  logic               w_last;
`ifdef MODEXP_SKIP_LZ_EN
  logic [CNT_W-1:0]   w_lz_idx;
`endif

  assign w_cur_bit = r_e_sh[EXP_W-1];
  assign w_last    = (r_cnt == {CNT_W{1'b0}});
  assign w_redc    = redc(w_op_a, w_op_b);

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_result = r_result;

`ifdef MODEXP_SKIP_LZ_EN
  // Priority encode the incoming exponent for leading-zero skipping.
  always_comb begin
    w_lz_idx = msb_index(i_exp);
  end
`endif

  // Operand-select muxes in front of the shared multiplier/REDC pair.
  always_comb begin
    w_op_a = 65'd0;
    w_op_b = 65'd0;
    case (r_state)
      S_TO_MONT: begin
        w_op_a = r_base;
        w_op_b = R2_MOD_N;
      end
      S_SQR: begin
        w_op_a = r_acc;
        w_op_b = r_acc;
      end
      S_MUL: begin
        w_op_a = r_acc;
        w_op_b = r_bm;
      end
      S_FROM_MONT: begin
        w_op_a = r_acc;
        w_op_b = 65'd1;
      end
      default: begin
        w_op_a = 65'd0;
        w_op_b = 65'd0;
      end
    endcase
  end

  // Next-state logic of the exponentiation sequencer.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next = S_TO_MONT;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_TO_MONT: begin
`ifdef MODEXP_SKIP_LZ_EN
        if (r_e_sh == {EXP_W{1'b0}}) begin
          w_next = S_FROM_MONT;
        end else begin
          w_next = S_SQR;
        end
`else
        w_next = S_SQR;
`endif
      end
      S_SQR: begin
        if (w_cur_bit) begin
          w_next = S_MUL;
        end else if (w_last) begin
          w_next = S_FROM_MONT;
        end else begin
          w_next = S_SQR;
        end
      end
      S_MUL: begin
        if (w_last) begin
          w_next = S_FROM_MONT;
        end else begin
          w_next = S_SQR;
        end
      end
      S_FROM_MONT: begin
        w_next = S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Datapath registers and registered status outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_base   <= 65'd0;
      r_acc    <= 65'd0;
      r_bm     <= 65'd0;
      r_e_sh   <= {EXP_W{1'b0}};
      r_cnt    <= {CNT_W{1'b0}};
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= 65'd0;
    end else begin
      r_busy <= (w_next != S_IDLE);
      r_done <= (w_next == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_base <= i_base;
            r_acc  <= R_MOD_N;
`ifdef MODEXP_SKIP_LZ_EN
            r_cnt  <= w_lz_idx;
            r_e_sh <= i_exp << (CNT_W'(EXP_W - 1) - w_lz_idx);
`else
            r_cnt  <= CNT_W'(EXP_W - 1);
            r_e_sh <= i_exp;
`endif
          end
        end
        S_TO_MONT: begin
          r_bm <= w_redc;
        end
        S_SQR: begin
          r_acc <= w_redc;
          // A set bit keeps e_sh/cnt in place so MUL consumes it.
          if (!w_cur_bit) begin
            r_e_sh <= r_e_sh << 1;
            if (!w_last) begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
        end
        S_MUL: begin
          r_acc  <= w_redc;
          r_e_sh <= r_e_sh << 1;
          if (!w_last) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_FROM_MONT: begin
          r_result <= w_redc;
        end
        default: begin
          r_acc <= r_acc;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_modexp_ctrl.sv
// Self-checking bench for modexp_ctrl: scoreboard of expected results and
// latencies filled by the stimulus, drained by an independent done monitor.
module tb_modexp_ctrl;

  localparam logic [64:0] MOD_N = 65'd21536215303153667899;

  typedef struct {
    logic [64:0] res;
    int          k;
    int          start_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic [64:0] i_base;
  logic [63:0] i_exp;
  logic        o_busy;
  logic        o_done;
  logic [64:0] o_result;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic prev_done = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  modexp_ctrl dut (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_start (i_start),
    .i_base  (i_base),
    .i_exp   (i_exp),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_result(o_result)
  );

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Latency from the rules: TO_MONT + scanned bits + one MUL per set bit + FROM_MONT.
  function automatic int k_of(input logic [63:0] e);
    int b;
`ifdef MODEXP_SKIP_LZ_EN
    b = 0;
    for (int i = 0; i < 64; i++) if (e[i]) b = i + 1;
`else
    b = 64;
`endif
    return 1 + b + $countones(e) + 1;
  endfunction

  // Plain modular exponentiation with wide arithmetic.
  function automatic logic [64:0] ref_pow(input logic [64:0] b, input logic [63:0] e);
    logic [129:0] r, x, n;
    n = {65'd0, MOD_N};
    r = 130'd1;
    x = {65'd0, b} % n;
    for (int i = 0; i < 64; i++) begin
      if (e[i]) r = (r * x) % n;
      x = (x * x) % n;
    end
    return r[64:0];
  endfunction

  // Monitor: compare every done pulse against the scoreboard head.
  always @(negedge clk) begin
    if (prev_done) begin
      check("busy_fall", {64'd0, o_busy}, 65'd0);
      check("done_width", {64'd0, o_done}, 65'd0);
    end
    prev_done <= o_done;
    if (o_done) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no done (t=%0t)", $time);
      end else begin
        check("result", o_result, sb[0].res);
        check("latency", 65'(cyc - sb[0].start_cyc), 65'(sb[0].k));
        check("busy_at_done", {64'd0, o_busy}, 65'd1);
        sb.pop_front();
      end
    end
  end

  task automatic run_op(input logic [64:0] b, input logic [63:0] e,
                        input logic [64:0] expv, input bit repulse);
    exp_t it;
    int   n;
    it.res       = expv;
    it.k         = k_of(e);
    it.start_cyc = cyc + 1;
    sb.push_back(it);
    i_base  = b;
    i_exp   = e;
    i_start = 1'b1;
    @(negedge clk); #1;
    if (!repulse) i_start = 1'b0;
    check("busy_rise", {64'd0, o_busy}, 65'd1);
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      if (repulse) begin
        i_base = {$urandom(), $urandom(), 1'b0};
        i_exp  = {$urandom(), $urandom()};
      end
      @(negedge clk); #1;
      n++;
    end
    i_start = 1'b0;
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done in %0d cycles expected done", n);
      sb.delete();
    end
    @(negedge clk); #1;
  endtask

  initial begin
    logic [95:0]  w96;
    logic [64:0]  b;
    logic [63:0]  e;

    i_rst   = 1'b1;
    i_start = 1'b0;
    i_base  = 65'd0;
    i_exp   = 64'd0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", {64'd0, o_busy}, 65'd0);
    check("rst_done", {64'd0, o_done}, 65'd0);
    check("rst_result", o_result, 65'd0);
    i_rst = 1'b0;
    @(negedge clk); #1;

    // Directed cases with known answers.
    run_op(65'd2, 64'd10, 65'd1024, 1'b0);
    run_op(65'd5, 64'd0, 65'd1, 1'b0);
    run_op(MOD_N - 65'd1, 64'd2, 65'd1, 1'b0);
    run_op(65'd7, 64'd1, 65'd7, 1'b0);

    // start held high for the whole run: one done only.
    run_op(65'd3, 64'd5, 65'd243, 1'b1);
    repeat (4) @(negedge clk);
    #1;
    check("no_restart_busy", {64'd0, o_busy}, 65'd0);
    check("result_hold", o_result, 65'd243);

    // Abort with a one-cycle reset in the middle of a run.
    i_base  = 65'd11;
    i_exp   = 64'hF0F0_1234_5678_9ABC;
    i_start = 1'b1;
    @(negedge clk); #1;
    i_start = 1'b0;
    repeat (19) @(negedge clk);
    #1;
    check("busy_mid_run", {64'd0, o_busy}, 65'd1);
    i_rst = 1'b1;
    @(negedge clk); #1;
    i_rst = 1'b0;
    check("abort_busy", {64'd0, o_busy}, 65'd0);
    check("abort_done", {64'd0, o_done}, 65'd0);
    check("abort_result", o_result, 65'd0);
    run_op(65'd2, 64'd3, 65'd8, 1'b0);

    // Randomized operands against the reference model.
    for (int t = 0; t < 200; t++) begin
      w96 = {$urandom(), $urandom(), $urandom()};
      b   = 65'({34'd0, w96} % {65'd0, MOD_N});
      e   = {$urandom(), $urandom()};
      e   = e >> $urandom_range(0, 63);
      if ((t % 4) == 1) e = e & {$urandom(), $urandom()};
      if ((t % 25) == 3) e = 64'd0;
      run_op(b, e, ref_pow(b, e), 1'b0);
    end

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
